// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and default widths for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory sequencer for fetch and load/store requesters
// Data wins arbitration unless fetch has already lost STARVE_MAX grants in a row.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_valid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_valid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [1:0]    state;
  logic          owner;
  logic          we_r;
  logic [LW-1:0] lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          grant_d;
  logic          starved;

  assign starved = (starve_cnt == SW'(STARVE_MAX));
  assign grant_d = d_req && !(if_req && starved);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_I;
      we_r       <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      // The strobe is a single-cycle pulse issued on the grant edge.
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (d_req || if_req) begin
            owner     <= grant_d ? OWN_D : OWN_I;
            we_r      <= grant_d && d_we;
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_be    <= grant_d ? d_be : '1;
            mem_wdata <= grant_d ? d_wdata : '0;
            mem_en    <= 1'b1;
            mem_we    <= grant_d && d_we;
            lat_cnt   <= '0;
            state     <= S_ACCESS;
            if (grant_d && if_req) begin
              if (!starved) starve_cnt <= starve_cnt + 1'b1;
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        S_ACCESS: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_cnt == LW'(MEM_LAT - 1)) state <= S_RESP;
        end
        S_RESP: begin
          if (owner == OWN_I) if_rdata <= mem_rdata;
          else if (!we_r)     d_rdata  <= mem_rdata;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign if_valid = (state == S_DONE) && (owner == OWN_I);
  assign d_valid  = (state == S_DONE) && (owner == OWN_D);
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter at MEM_LAT=1 and MEM_LAT=4
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // instance a: MEM_LAT=1
  logic        a_rst, a_if_req, a_if_valid, a_d_req, a_d_we, a_d_valid, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_if_addr, a_if_rdata, a_d_addr, a_d_wdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_d_be, a_mem_be;
  logic [31:0] a_rd_val = 32'h0;
  logic        a_pipe = 1'b0;

  always @(posedge clk) a_pipe <= a_mem_en;
  assign a_mem_rdata = a_pipe ? a_rd_val : 32'hBAD0BAD0;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(3)) dut_a (
    .clk(clk), .rst(a_rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_valid(a_if_valid), .if_rdata(a_if_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_valid(a_d_valid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  // instance b: MEM_LAT=4
  logic        b_rst, b_if_req, b_if_valid, b_d_req, b_d_we, b_d_valid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_d_be, b_mem_be;
  logic [31:0] b_rd_val = 32'h0;
  logic [3:0]  b_pipe = 4'h0;

  always @(posedge clk) b_pipe <= {b_pipe[2:0], b_mem_en};
  assign b_mem_rdata = b_pipe[3] ? b_rd_val : 32'hBAD0BAD0;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(4), .STARVE_MAX(3)) dut_b (
    .clk(clk), .rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_valid(b_if_valid), .if_rdata(b_if_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_be(b_d_be), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_valid(b_d_valid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_addr [8];
    int n, last, got;

    a_rst = 1'b1; a_if_req = 1'b0; a_if_addr = '0; a_d_req = 1'b0; a_d_we = 1'b0;
    a_d_be = '0; a_d_addr = '0; a_d_wdata = '0;
    b_rst = 1'b1; b_if_req = 1'b0; b_if_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_be = '0; b_d_addr = '0; b_d_wdata = '0;
    tick();
    tick();
    check("rst_busy",     32'(a_busy), 0);
    check("rst_if_valid", 32'(a_if_valid), 0);
    check("rst_d_valid",  32'(a_d_valid), 0);
    check("rst_mem_en",   32'(a_mem_en), 0);
    check("rst_mem_addr", a_mem_addr, 0);
    check("rst_if_rdata", a_if_rdata, 0);
    check("rst_b_busy",   32'(b_busy), 0);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // fetch, MEM_LAT=1
    a_rd_val = 32'h00500093; a_if_req = 1'b1; a_if_addr = 32'h10;
    check("f_c0_busy", 32'(a_busy), 0);
    tick();
    check("f_c1_mem_en", 32'(a_mem_en), 1);
    check("f_c1_addr",   a_mem_addr, 32'h10);
    check("f_c1_we",     32'(a_mem_we), 0);
    check("f_c1_busy",   32'(a_busy), 1);
    tick();
    check("f_c2_mem_en",   32'(a_mem_en), 0);
    check("f_c2_if_valid", 32'(a_if_valid), 0);
    tick();
    check("f_c3_if_valid", 32'(a_if_valid), 1);
    check("f_c3_if_rdata", a_if_rdata, 32'h00500093);
    check("f_c3_d_valid",  32'(a_d_valid), 0);
    a_if_req = 1'b0;
    tick();
    check("f_c4_if_valid", 32'(a_if_valid), 0);
    check("f_c4_busy",     32'(a_busy), 0);

    // store
    a_rd_val = 32'h55555555;
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h200; a_d_wdata = 32'hDEADBEEF; a_d_be = 4'hF;
    tick();
    check("s_c1_mem_en", 32'(a_mem_en), 1);
    check("s_c1_we",     32'(a_mem_we), 1);
    check("s_c1_addr",   a_mem_addr, 32'h200);
    check("s_c1_wdata",  a_mem_wdata, 32'hDEADBEEF);
    check("s_c1_be",     32'(a_mem_be), 32'hF);
    tick();
    check("s_c2_mem_en", 32'(a_mem_en), 0);
    check("s_c2_we",     32'(a_mem_we), 0);
    tick();
    check("s_c3_d_valid", 32'(a_d_valid), 1);
    check("s_c3_d_rdata", a_d_rdata, 0);
    a_d_req = 1'b0; a_d_we = 1'b0;
    tick();

    // starvation guard: D,D,D,I,D,D,D,I, grants MEM_LAT+3 apart
    exp_addr = '{32'h300, 32'h300, 32'h300, 32'h100, 32'h300, 32'h300, 32'h300, 32'h100};
    a_if_addr = 32'h100; a_d_addr = 32'h300;
    a_if_req = 1'b1; a_d_req = 1'b1;
    n = 0; last = 0;
    for (int c = 1; c <= 60 && n < 8; c++) begin
      tick();
      if (a_mem_en) begin
        check($sformatf("grant%0d_addr", n), a_mem_addr, exp_addr[n]);
        if (n > 0) check($sformatf("grant%0d_gap", n), 32'(c - last), 4);
        last = c;
        n++;
      end
    end
    check("grant_count", 32'(n), 8);
    a_if_req = 1'b0; a_d_req = 1'b0;
    for (int k = 0; k < 20 && a_busy; k++) tick();
    check("starve_drain_busy", 32'(a_busy), 0);

    // fetch request rising together with d_valid
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h300; a_rd_val = 32'h77;
    for (int k = 0; k < 10 && !a_d_valid; k++) tick();
    check("bb_d_valid",  32'(a_d_valid), 1);
    check("bb_d_rdata",  a_d_rdata, 32'h77);
    a_d_req = 1'b0; a_if_req = 1'b1; a_if_addr = 32'h44; a_rd_val = 32'h88;
    tick();
    check("bb_idle_busy",   32'(a_busy), 0);
    tick();
    check("bb_mem_en",      32'(a_mem_en), 1);
    check("bb_mem_addr",    a_mem_addr, 32'h44);
    tick();
    check("bb_early_valid", 32'(a_if_valid), 0);
    tick();
    check("bb_if_valid",    32'(a_if_valid), 1);
    check("bb_if_rdata",    a_if_rdata, 32'h88);
    a_if_req = 1'b0;

    // MEM_LAT=4 load
    b_rd_val = 32'h1234; b_d_req = 1'b1; b_d_addr = 32'h40; b_d_we = 1'b0;
    check("l4_c0_busy", 32'(b_busy), 0);
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("l4_c%0d_busy", c),    32'(b_busy), 1);
      check($sformatf("l4_c%0d_d_valid", c), 32'(b_d_valid), (c == 6) ? 1 : 0);
      check($sformatf("l4_c%0d_d_rdata", c), b_d_rdata, (c == 6) ? 32'h1234 : 32'h0);
      if (c == 1) check("l4_c1_mem_addr", b_mem_addr, 32'h40);
    end
    b_d_req = 1'b0;
    tick();
    check("l4_idle_busy", 32'(b_busy), 0);

    // reset during ACCESS, then the held request restarts cleanly
    b_d_addr = 32'h80; b_rd_val = 32'hCAFE; b_d_req = 1'b1;
    tick();
    check("r_c1_mem_en", 32'(b_mem_en), 1);
    tick();
    b_rst = 1'b1;
    tick();
    check("r_c3_busy",     32'(b_busy), 0);
    check("r_c3_d_valid",  32'(b_d_valid), 0);
    check("r_c3_mem_en",   32'(b_mem_en), 0);
    check("r_c3_mem_addr", b_mem_addr, 0);
    check("r_c3_d_rdata",  b_d_rdata, 0);
    b_rst = 1'b0;
    got = 0;
    for (int c = 4; c <= 12; c++) begin
      tick();
      if (b_d_valid && got == 0) got = c;
    end
    check("r_rearm_cycle", 32'(got), 9);
    check("r_rearm_rdata", b_d_rdata, 32'hCAFE);
    b_d_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single-ported unified instruction/data memory between two requesters: the fetch stage (IF) and the load/store stage (D).
- One access at a time. Fixed read latency MEM_LAT.
- Data requests have priority, with a starvation guard for fetch.
- Sits between the pipeline (PC/IF and MEM stages) and the memory macro. The core stalls on its own req until the matching valid arrives.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8 wide)
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata; must be >=1
- STARVE_MAX, 3, consecutive data grants allowed while fetch waits

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  AW  fetch address; stable while if_req
- if_valid  out  1  one-cycle fetch completion pulse
- if_rdata  out  DW  fetched word; held until next fetch completes
- d_req  in  1  data request; held until d_valid
- d_we  in  1  1=store, 0=load
- d_be  in  DW/8  byte enables
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_valid  out  1  one-cycle data completion pulse (loads and stores)
- d_rdata  out  DW  load data; held until next data completion
- mem_en  out  1  access strobe, exactly one cycle per access
- mem_we  out  1  write enable; only asserted together with mem_en
- mem_be  out  DW/8  byte enables to memory
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid MEM_LAT cycles after mem_en
- busy  out  1  high in any state except IDLE

Behaviour:
- States: IDLE, ACCESS, RESP, DONE. Owner register: OWN_I or OWN_D.
- Reset: state=IDLE; if_valid, d_valid, mem_en, mem_we, busy=0; mem_addr, mem_wdata, mem_be, if_rdata, d_rdata=0; starve_cnt=0.
- Reset mid-operation: the in-flight access is abandoned and no valid is emitted. A store whose mem_en already fired is not undone.
- IDLE arbitration:
  - d_req only -> grant D.
  - if_req only -> grant I.
  - Both -> grant D, unless starve_cnt==STARVE_MAX, in which case grant I.
  - Neither -> stay in IDLE.
- On grant: register owner, addr, be, wdata and we (forced 0 for fetch). lat_cnt=0. Next state ACCESS.
- ACCESS:
  - mem_en=1 on the first ACCESS cycle only; mem_we=registered we on that cycle only.
  - mem_addr, mem_be, mem_wdata are held through ACCESS and RESP.
  - lat_cnt increments each cycle; when lat_cnt==MEM_LAT-1, next state RESP.
- RESP: capture mem_rdata into the owner's rdata register (stores leave d_rdata unchanged). Next state DONE.
- DONE: owner's valid=1 for this cycle only. Next state IDLE.
  - The requester drops req at this edge, so IDLE never re-issues a completed request.
- Latency: req seen in IDLE at cycle 0 -> mem_en at cycle 1 -> valid at cycle MEM_LAT+2. Minimum 4 cycles per access including IDLE.
- starve_cnt:
  - +1 on a D grant while if_req=1, saturating at STARVE_MAX.
  - Cleared on an I grant, or on a D grant with if_req=0.
- Requests arriving while busy wait; nothing is queued beyond the held req.
- A req dropped mid-access (protocol violation): the access still completes and valid still pulses.
- Valid outputs are decoded from registered state only; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package (defines file): state encodings (IDLE/ACCESS/RESP/DONE), owner encodings (OWN_I/OWN_D), default widths.
- No sub-module; the latency counter and arbitration stay inline (~180 lines).

Test Plan:
- Reset, then if_req=1, if_addr=0x10, MEM_LAT=1, mem_rdata=0x00500093 -> mem_en at cycle 1 with addr 0x10, mem_we=0; if_valid at cycle 3 with if_rdata=0x00500093; d_valid never asserts.
- Store d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_be=0xF -> single mem_en with mem_we=1 and those values; d_valid at cycle 3; d_rdata unchanged.
- if_req and d_req held high continuously, STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I; each grant separated by MEM_LAT+3 cycles.
- MEM_LAT=4, load from 0x40 with mem_rdata model returning 0x1234 four cycles after mem_en -> d_rdata=0x1234; d_valid at cycle 6; busy high cycles 1-6.
- rst pulsed during ACCESS of a load -> next cycle state IDLE, no d_valid, all outputs at reset values; a re-issued request completes normally.
- if_req rises in the same cycle d_valid pulses -> fetch granted in the following IDLE cycle; if_valid exactly MEM_LAT+2 cycles later.
